// File: rtl/ysyx_22040931_imm_enc_pkg.sv
// Shared defines for the ysyx_22040931 immediate encoder: format codes, field constants
// and the sign-extension helper used by the representability check.
package ysyx_22040931_imm_enc_pkg;

  localparam logic [2:0] ysyx_22040931_It = 3'd1;
  localparam logic [2:0] ysyx_22040931_St = 3'd2;
  localparam logic [2:0] ysyx_22040931_Bt = 3'd3;
  localparam logic [2:0] ysyx_22040931_Jt = 3'd4;
  localparam logic [2:0] ysyx_22040931_Ut = 3'd5;

  localparam int FieldW = 25;
  localparam logic [FieldW-1:0] ysyx_22040931_Zero = '0;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  opt;
  } immReq_t;

  // True when v equals the sign-extension of v[msb:0]: the bits from msb upward
  // must be all zeros or all ones.
  function automatic logic fitsSigned(input logic [63:0] v, input int msb);
    logic [63:0] upper;
    logic [63:0] mask;
    upper = v >> msb;
    mask  = {64{1'b1}} >> msb;
    return (upper == 64'd0) || (upper == mask);
  endfunction

endpackage

// File: rtl/ysyx_22040931_imm_enc_pack.sv
// Combinational packer: places immediate bits into instruction bits [31:7] and flags values
// the chosen format cannot hold. The check exists only with YSYX_22040931_IMM_ENC_CHK_EN.
module ysyx_22040931_imm_pack
  import ysyx_22040931_imm_enc_pkg::*;
(
  input  logic [63:0]       i_imm,
  input  logic [2:0]        i_opt,
  output logic [FieldW-1:0] o_field,
  output logic              o_err
);

  always_comb begin
    o_field = ysyx_22040931_Zero;
    case (i_opt)
      ysyx_22040931_It: o_field = {i_imm[11:0], 13'd0};
      ysyx_22040931_St: o_field = {i_imm[11:5], 13'd0, i_imm[4:0]};
      ysyx_22040931_Bt: o_field = {i_imm[12], i_imm[10:5], 13'd0, i_imm[4:1], i_imm[11]};
      ysyx_22040931_Jt: o_field = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], 5'd0};
      ysyx_22040931_Ut: o_field = {i_imm[31:12], 5'd0};
      default:          o_field = ysyx_22040931_Zero;
    endcase
  end

`ifdef YSYX_22040931_IMM_ENC_CHK_EN
  logic w_fits12;
  logic w_fits13;
  logic w_fits21;
  logic w_fits32;

  assign w_fits12 = fitsSigned(i_imm, 11);
  assign w_fits13 = fitsSigned(i_imm, 12);
  assign w_fits21 = fitsSigned(i_imm, 20);
  assign w_fits32 = fitsSigned(i_imm, 31);

  // Branch and jump targets must be even; upper immediates must have a clear low 12 bits.
  always_comb begin
    o_err = 1'b1;
    case (i_opt)
      ysyx_22040931_It: o_err = !w_fits12;
      ysyx_22040931_St: o_err = !w_fits12;
      ysyx_22040931_Bt: o_err = i_imm[0] || !w_fits13;
      ysyx_22040931_Jt: o_err = i_imm[0] || !w_fits21;
      ysyx_22040931_Ut: o_err = (i_imm[11:0] != 12'd0) || !w_fits32;
      default:          o_err = 1'b1;
    endcase
  end
`else
  logic w_unusedImm;

  assign w_unusedImm = ^i_imm[63:32];
  assign o_err       = 1'b0;
`endif

endmodule

// File: rtl/ysyx_22040931_imm_enc.sv
// Two-stage immediate encoder pipeline with valid/ready handshakes on both sides.
// Define YSYX_22040931_IMM_ENC_CHK_EN to build the representability check and error counter.
module ysyx_22040931_imm_enc
  import ysyx_22040931_imm_enc_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [63:0]       in_imm,
  input  logic [2:0]        in_opt,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FieldW-1:0] out_field,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err,
  output logic [15:0]       err_cnt
);

  logic              r_s1Valid;
  immReq_t           r_s1Req;
  logic [TAG_W-1:0]  r_s1Tag;
  logic              r_s2Valid;
  logic [FieldW-1:0] r_outField;
  logic [TAG_W-1:0]  r_outTag;
  logic              w_s1Adv;
  logic [FieldW-1:0] w_packField;
  logic              w_packErr;

  // S1 hands over whenever S2 is empty or draining this cycle.
  assign w_s1Adv  = !r_s2Valid || out_ready;
  assign in_ready = !r_s1Valid || w_s1Adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1Valid <= 1'b0;
      r_s1Req   <= '0;
      r_s1Tag   <= '0;
    end else if (in_ready) begin
      r_s1Valid <= in_valid;
      if (in_valid) begin
        r_s1Req <= '{imm: in_imm, opt: in_opt};
        r_s1Tag <= in_tag;
      end
    end
  end

  ysyx_22040931_imm_pack u_pack (
    .i_imm   (r_s1Req.imm),
    .i_opt   (r_s1Req.opt),
    .o_field (w_packField),
    .o_err   (w_packErr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2Valid  <= 1'b0;
      r_outField <= '0;
      r_outTag   <= '0;
    end else if (w_s1Adv) begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        r_outField <= w_packField;
        r_outTag   <= r_s1Tag;
      end
    end
  end

  assign out_valid = r_s2Valid;
  assign out_field = r_outField;
  assign out_tag   = r_outTag;

`ifdef YSYX_22040931_IMM_ENC_CHK_EN
  logic        r_outErr;
  logic [15:0] r_errCnt;

  // The counter counts delivered results, so it advances on the output transfer, not on entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outErr <= 1'b0;
      r_errCnt <= 16'd0;
    end else begin
      if (w_s1Adv && r_s1Valid) begin
        r_outErr <= w_packErr;
      end
      if (r_s2Valid && out_ready && r_outErr && (r_errCnt != 16'hFFFF)) begin
        r_errCnt <= r_errCnt + 16'd1;
      end
    end
  end

  assign out_err = r_outErr;
  assign err_cnt = r_errCnt;
`else
  assign out_err = w_packErr;
  assign err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_ysyx_22040931_imm_enc.sv
// Self-checking bench for ysyx_22040931_imm_enc: directed formats, backpressure, random stream
// against a numeric reference model, and reset with requests in flight.
module tb_ysyx_22040931_imm_enc;

  localparam int TagW = 4;
  localparam logic [2:0] OptI = 3'd1;
  localparam logic [2:0] OptS = 3'd2;
  localparam logic [2:0] OptB = 3'd3;
  localparam logic [2:0] OptJ = 3'd4;
  localparam logic [2:0] OptU = 3'd5;
`ifdef YSYX_22040931_IMM_ENC_CHK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic            inValid;
  logic            inReady;
  logic [63:0]     inImm;
  logic [2:0]      inOpt;
  logic [TagW-1:0] inTag;
  logic            outValid;
  logic            outReady;
  logic [24:0]     outField;
  logic [TagW-1:0] outTag;
  logic            outErr;
  logic [15:0]     errCnt;

  int errors = 0;
  int checks = 0;
  int expErrCnt = 0;

  typedef struct {
    logic [63:0]     imm;
    logic [2:0]      opt;
    logic [TagW-1:0] tag;
    logic [24:0]     field;
    logic            err;
  } item_t;

  item_t expQ[$];
  item_t obsQ[$];

  logic [63:0] dImm [11] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h800, 64'h3, 64'h1000,
                             64'hFFFF_FFFF_FFFF_FFFE, 64'h1234_5000, 64'h5,
                             64'hFFFF_FFFF_FFFF_FFFB, 64'h800, 64'h8000_0000, 64'h123};
  logic [2:0]  dOpt [11] = '{OptI, OptB, OptB, OptB, OptJ, OptU, 3'd7, OptS, OptI, OptU, 3'd0};
  logic [24:0] dField [11] = '{25'h1FFE000, 25'h0000001, 25'h0000002, 25'h1000000,
                               25'h1FFFFE0, 25'h02468A0, 25'h0, 25'h1FC001B,
                               25'h1000000, 25'h1000000, 25'h0};
  bit          dErr [11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  ysyx_22040931_imm_enc #(.TAG_W(TagW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .in_imm    (inImm),
    .in_opt    (inOpt),
    .in_tag    (inTag),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_field (outField),
    .out_tag   (outTag),
    .out_err   (outErr),
    .err_cnt   (errCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: representability as numeric ranges on the signed value.
  function automatic bit repOk(input logic [63:0] imm, input logic [2:0] opt);
    longint s;
    s = imm;
    case (opt)
      OptI, OptS: return (s >= -2048) && (s <= 2047);
      OptB: return (s % 2 == 0) && (s >= -4096) && (s <= 4095);
      OptJ: return (s % 2 == 0) && (s >= -1048576) && (s <= 1048575);
      OptU: return (s % 4096 == 0) && (s >= -64'sd2147483648) && (s <= 64'sd2147483647);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [24:0] modelField(input logic [63:0] imm, input logic [2:0] opt);
    longint unsigned u;
    longint unsigned f;
    u = imm;
    f = 0;
    case (opt)
      OptI: f = (u & 64'hFFF) << 13;
      OptS: f = (((u >> 5) & 64'h7F) << 18) | (u & 64'h1F);
      OptB: f = (((u >> 12) & 64'h1) << 24) | (((u >> 5) & 64'h3F) << 18)
              | (((u >> 1) & 64'hF) << 1) | ((u >> 11) & 64'h1);
      OptJ: f = (((u >> 20) & 64'h1) << 24) | (((u >> 1) & 64'h3FF) << 14)
              | (((u >> 11) & 64'h1) << 13) | (((u >> 12) & 64'hFF) << 5);
      OptU: f = ((u >> 12) & 64'hFFFFF) << 5;
      default: f = 0;
    endcase
    return f[24:0];
  endfunction

  // Instruction-side immediate decoder, used for the round trip.
  function automatic logic [63:0] decode(input logic [24:0] f, input logic [2:0] opt);
    logic [63:0] v;
    case (opt)
      OptI: v = {{52{f[24]}}, f[24:13]};
      OptS: v = {{52{f[24]}}, f[24:18], f[4:0]};
      OptB: v = {{51{f[24]}}, f[24], f[0], f[23:18], f[4:1], 1'b0};
      OptJ: v = {{43{f[24]}}, f[24], f[12:5], f[13], f[23:14], 1'b0};
      OptU: v = {{32{f[24]}}, f[24:5], 12'd0};
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic [63:0] genImm(input logic [2:0] opt);
    logic [63:0] r;
    r = {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) return r;
    case (opt)
      OptI, OptS: return {{52{r[11]}}, r[11:0]};
      OptB: return {{51{r[12]}}, r[12:1], 1'b0};
      OptJ: return {{43{r[20]}}, r[20:1], 1'b0};
      OptU: return {{32{r[31]}}, r[31:12], 12'd0};
      default: return r;
    endcase
  endfunction

  // Transfers are recorded on the falling edge, where valid/ready are stable.
  always @(negedge clk) begin
    item_t e;
    if (rst !== 1'b1) begin
      if (inValid && inReady) begin
        e.imm = inImm;
        e.opt = inOpt;
        e.tag = inTag;
        e.field = modelField(inImm, inOpt);
        e.err = ChkEn && !repOk(inImm, inOpt);
        expQ.push_back(e);
        if (e.err) expErrCnt++;
      end
      if (outValid && outReady) begin
        e.imm = '0;
        e.opt = '0;
        e.tag = outTag;
        e.field = outField;
        e.err = outErr;
        obsQ.push_back(e);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time exceeded, got no finish, required finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic sendReq(input logic [63:0] imm, input logic [2:0] opt,
                         input logic [TagW-1:0] tag, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    inValid = 1'b1;
    inImm = imm;
    inOpt = opt;
    inTag = tag;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = inReady;
      n++;
      @(posedge clk);
      #1;
    end
    inValid = 1'b0;
  endtask

  task automatic waitObs(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(posedge clk);
      #1;
      if (obsQ.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic resetDut;
    rst = 1'b1;
    inValid = 1'b0;
    outReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    expQ.delete();
    obsQ.delete();
    expErrCnt = 0;
  endtask

  task automatic test_reset;
    resetDut();
    @(negedge clk);
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", outValid); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", inReady); end
    checks++; if (outField !== 25'd0) begin errors++; $display("[TB] FAIL reset_field: got %h expected 0", outField); end
    checks++; if (outTag !== '0) begin errors++; $display("[TB] FAIL reset_tag: got %h expected 0", outTag); end
    checks++; if (outErr !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", outErr); end
    checks++; if (errCnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_err_cnt: got %0d expected 0", errCnt); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed;
    outReady = 1'b1;
    for (int i = 0; i < 11; i++) begin
      int lat;
      bit ok;
      logic [15:0] cntBefore;
      logic expE;
      expE = ChkEn && dErr[i];
      cntBefore = errCnt;
      sendReq(dImm[i], dOpt[i], TagW'(i), ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL directed_accept[%0d]: got no in_ready, expected accept", i); end
      lat = 1;
      @(negedge clk);
      while (!outValid && lat < 20) begin
        @(posedge clk);
        #1;
        @(negedge clk);
        lat++;
      end
      checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL directed_latency[%0d]: got %0d expected 2", i, lat); end
      checks++; if (outField !== dField[i]) begin errors++; $display("[TB] FAIL directed_field[%0d]: got %h expected %h", i, outField, dField[i]); end
      checks++; if (outErr !== expE) begin errors++; $display("[TB] FAIL directed_err[%0d]: got %b expected %b", i, outErr, expE); end
      checks++; if (outTag !== TagW'(i)) begin errors++; $display("[TB] FAIL directed_tag[%0d]: got %h expected %h", i, outTag, TagW'(i)); end
      @(posedge clk);
      #1;
      checks++;
      if (errCnt !== 16'(cntBefore + expE)) begin
        errors++;
        $display("[TB] FAIL directed_err_cnt[%0d]: got %0d expected %0d", i, errCnt, 16'(cntBefore + expE));
      end
    end
  endtask

  task automatic test_backpressure;
    int idx;
    int cyc;
    bit ok;
    logic [24:0] hField;
    logic [TagW-1:0] hTag;
    logic hErr;
    idx = 0;
    expQ.delete();
    obsQ.delete();
    outReady = 1'b0;
    for (int c = 0; c < 5; c++) begin
      inValid = (idx < 4);
      inImm = 64'(idx * 8 + 3);
      inOpt = OptI;
      inTag = TagW'(10 + idx);
      @(negedge clk);
      if (c >= 2) begin
        checks++; if (inReady !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready[c%0d]: got %b expected 0", c, inReady); end
        checks++; if (idx !== 2) begin errors++; $display("[TB] FAIL bp_held_count[c%0d]: got %0d expected 2", c, idx); end
        checks++; if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL bp_out_valid[c%0d]: got %b expected 1", c, outValid); end
      end
      if (c == 2) begin
        hField = outField;
        hTag = outTag;
        hErr = outErr;
        checks++; if (outTag !== TagW'(10)) begin errors++; $display("[TB] FAIL bp_head_tag: got %h expected %h", outTag, TagW'(10)); end
      end
      if (c > 2) begin
        checks++;
        if ({outField, outTag, outErr} !== {hField, hTag, hErr}) begin
          errors++;
          $display("[TB] FAIL bp_stable[c%0d]: got %h/%h/%b expected %h/%h/%b", c, outField, outTag, outErr, hField, hTag, hErr);
        end
      end
      if (inValid && inReady) idx++;
      @(posedge clk);
      #1;
    end
    outReady = 1'b1;
    cyc = 0;
    while (idx < 4 && cyc < 50) begin
      inValid = 1'b1;
      inImm = 64'(idx * 8 + 3);
      inOpt = OptI;
      inTag = TagW'(10 + idx);
      @(negedge clk);
      if (inValid && inReady) idx++;
      @(posedge clk);
      #1;
      cyc++;
    end
    inValid = 1'b0;
    checks++; if (idx !== 4) begin errors++; $display("[TB] FAIL bp_accept_all: got %0d expected 4", idx); end
    waitObs(4, ok);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (obsQ.size() !== 4) begin errors++; $display("[TB] FAIL bp_delivered: got %0d expected 4", obsQ.size()); end
    for (int k = 0; k < 4 && k < obsQ.size(); k++) begin
      checks++;
      if (obsQ[k].tag !== TagW'(10 + k)) begin
        errors++;
        $display("[TB] FAIL bp_order[%0d]: got tag %h expected %h", k, obsQ[k].tag, TagW'(10 + k));
      end
      checks++;
      if (obsQ[k].field !== modelField(64'(k * 8 + 3), OptI)) begin
        errors++;
        $display("[TB] FAIL bp_field[%0d]: got %h expected %h", k, obsQ[k].field, modelField(64'(k * 8 + 3), OptI));
      end
    end
  endtask

  task automatic test_random;
    int sent;
    int cyc;
    bit ok;
    sent = 0;
    cyc = 0;
    expQ.delete();
    obsQ.delete();
    while (sent < 300 && cyc < 5000) begin
      outReady = ($urandom_range(0, 3) != 0);
      inValid = ($urandom_range(0, 3) != 0);
      inOpt = 3'($urandom_range(0, 7));
      inImm = genImm(inOpt);
      inTag = TagW'($urandom);
      @(negedge clk);
      if (inValid && inReady) sent++;
      @(posedge clk);
      #1;
      cyc++;
    end
    inValid = 1'b0;
    outReady = 1'b1;
    checks++; if (sent !== 300) begin errors++; $display("[TB] FAIL rand_sent: got %0d expected 300", sent); end
    waitObs(sent, ok);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (obsQ.size() !== expQ.size()) begin errors++; $display("[TB] FAIL rand_count: got %0d expected %0d", obsQ.size(), expQ.size()); end
    for (int k = 0; k < expQ.size() && k < obsQ.size(); k++) begin
      checks++; if (obsQ[k].field !== expQ[k].field) begin errors++; $display("[TB] FAIL rand_field[%0d]: got %h expected %h (opt %0d imm %h)", k, obsQ[k].field, expQ[k].field, expQ[k].opt, expQ[k].imm); end
      checks++; if (obsQ[k].err !== expQ[k].err) begin errors++; $display("[TB] FAIL rand_err[%0d]: got %b expected %b (opt %0d imm %h)", k, obsQ[k].err, expQ[k].err, expQ[k].opt, expQ[k].imm); end
      checks++; if (obsQ[k].tag !== expQ[k].tag) begin errors++; $display("[TB] FAIL rand_tag[%0d]: got %h expected %h", k, obsQ[k].tag, expQ[k].tag); end
      if (repOk(expQ[k].imm, expQ[k].opt)) begin
        checks++;
        if (decode(obsQ[k].field, expQ[k].opt) !== expQ[k].imm) begin
          errors++;
          $display("[TB] FAIL rand_roundtrip[%0d]: got %h expected %h", k, decode(obsQ[k].field, expQ[k].opt), expQ[k].imm);
        end
      end
    end
    checks++; if (errCnt !== 16'(expErrCnt)) begin errors++; $display("[TB] FAIL rand_err_cnt: got %0d expected %0d", errCnt, expErrCnt); end
  endtask

  task automatic test_reset_inflight;
    bit ok;
    outReady = 1'b0;
    inValid = 1'b1;
    inOpt = 3'd7;
    inImm = 64'h5;
    inTag = TagW'(1);
    @(posedge clk);
    #1;
    inTag = TagW'(2);
    @(posedge clk);
    #1;
    inValid = 1'b0;
    checks++; if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL inflight_out_valid: got %b expected 1", outValid); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL rst_inflight_out_valid: got %b expected 0", outValid); end
    checks++; if (errCnt !== 16'd0) begin errors++; $display("[TB] FAIL rst_inflight_err_cnt: got %0d expected 0", errCnt); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL rst_inflight_in_ready: got %b expected 1", inReady); end
    checks++; if (outField !== 25'd0) begin errors++; $display("[TB] FAIL rst_inflight_field: got %h expected 0", outField); end
    @(posedge clk);
    #1;
    expQ.delete();
    obsQ.delete();
    expErrCnt = 0;
    outReady = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (obsQ.size() !== 0) begin errors++; $display("[TB] FAIL rst_inflight_ghost: got %0d outputs expected 0", obsQ.size()); end
    sendReq(64'h7FF, OptI, TagW'(6), ok);
    waitObs(1, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL post_reset_output: got timeout expected 1 output"); end
    if (ok) begin
      checks++; if (obsQ[0].tag !== TagW'(6)) begin errors++; $display("[TB] FAIL post_reset_tag: got %h expected 6", obsQ[0].tag); end
      checks++; if (obsQ[0].field !== 25'h0FFE000) begin errors++; $display("[TB] FAIL post_reset_field: got %h expected 0ffe000", obsQ[0].field); end
    end
    checks++; if (errCnt !== 16'(expErrCnt)) begin errors++; $display("[TB] FAIL post_reset_err_cnt: got %0d expected %0d", errCnt, expErrCnt); end
  endtask

  initial begin
    rst = 1'b1;
    inValid = 1'b0;
    inImm = '0;
    inOpt = '0;
    inTag = '0;
    outReady = 1'b1;
    $display("[TB] start, check build=%0d", ChkEn);
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
